// File: rtl/cnn_pkg.sv
// Shared fixed-point constants, FSM states and helpers for the conv/pool engine.
package cnn_pkg;

    localparam int unsigned CNN_DATA_W = 20;
    localparam int unsigned CNN_FRAC   = 16;
    localparam int unsigned CNN_MAX_W  = 64;

    typedef enum logic [2:0] {
        IDLE,
        CONV_RD,
        CONV_FIN,
        CONV_WR,
        POOL_RD,
        POOL_WR,
        FLAT_WR,
        DONE
    } cnn_state_t;

    function automatic int unsigned csel_l0(input int unsigned k);
        return k + 1;
    endfunction

    function automatic int unsigned csel_l1(input int unsigned k, input int unsigned num_ker);
        return num_ker + k + 1;
    endfunction

    function automatic int unsigned csel_flat(input int unsigned num_ker);
        return 2 * num_ker + 1;
    endfunction

    // Round half up at the binary point, clamp negatives to 0 and large positives to the data max.
    function automatic logic [CNN_MAX_W-1:0] round_relu_sat(input logic signed [CNN_MAX_W-1:0] acc,
                                                            input int unsigned data_w,
                                                            input int unsigned frac);
        logic signed [CNN_MAX_W-1:0] shifted;
        logic signed [CNN_MAX_W-1:0] rnd;
        logic signed [CNN_MAX_W-1:0] lim;
        lim     = $signed((CNN_MAX_W'(1) << (data_w - 1)) - CNN_MAX_W'(1));
        shifted = acc >>> frac;
        rnd     = shifted + $signed(CNN_MAX_W'(acc[frac-1]));
        if (acc < 0)
            return '0;
        if (rnd > lim)
            return lim;
        return rnd;
    endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One kernel lane: 3x3 multiply-accumulate, bias add and output conversion.
module conv_mac_lane
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W = CNN_DATA_W,
    parameter int unsigned FRAC   = CNN_FRAC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     acc_en,
    input  logic                     bias_en,
    input  logic signed [DATA_W-1:0] pix,
    input  logic signed [DATA_W-1:0] weight,
    input  logic signed [DATA_W-1:0] bias,
    output logic        [DATA_W-1:0] out
);

    localparam int unsigned ACC_W = 2 * DATA_W + 4;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [ACC_W-1:0]    acc;

    assign prod     = pix * weight;
    assign prod_ext = $signed({{4{prod[2*DATA_W-1]}}, prod});
    assign bias_ext = $signed({{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias}) <<< FRAC;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (acc_en)
            acc <= acc + prod_ext;
        else if (bias_en)
            acc <= acc + bias_ext;
    end

    assign out = DATA_W'(round_relu_sat($signed({{(CNN_MAX_W-ACC_W){acc[ACC_W-1]}}, acc}), DATA_W, FRAC));

endmodule

// File: rtl/conv_pool_engine.sv
// 3x3 multi-kernel convolution with ReLU, optional 2x2 max pooling and interleaved flatten.
module conv_pool_engine
    import cnn_pkg::*;
#(
    parameter  int unsigned IMG_W   = 64,
    parameter  int unsigned DATA_W  = CNN_DATA_W,
    parameter  int unsigned FRAC    = CNN_FRAC,
    parameter  int unsigned NUM_KER = 2,
    parameter  int unsigned POOL_EN = 1,
    localparam int unsigned LG      = $clog2(IMG_W),
    localparam int unsigned AW      = 2 * LG,
    localparam int unsigned KAW     = $clog2(NUM_KER * 10),
    localparam int unsigned CSW     = $clog2(2 * NUM_KER + 2)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    output logic              busy,
    input  logic              ker_we,
    input  logic [KAW-1:0]    ker_addr,
    input  logic [DATA_W-1:0] ker_data,
    output logic [AW-1:0]     iaddr,
    input  logic [DATA_W-1:0] idata,
    output logic              cwr,
    output logic [AW-1:0]     caddr_wr,
    output logic [DATA_W-1:0] cdata_wr,
    output logic              crd,
    output logic [AW-1:0]     caddr_rd,
    input  logic [DATA_W-1:0] cdata_rd,
    output logic [CSW-1:0]    csel
);

    localparam int unsigned     KW     = (NUM_KER > 1) ? $clog2(NUM_KER) : 1;
    localparam logic [LG-1:0]   LAST   = LG'(IMG_W - 1);
    localparam logic [LG-1:0]   LAST2  = LG'(IMG_W - 2);
    localparam logic [KW-1:0]   K_LAST = KW'(NUM_KER - 1);

    cnn_state_t state, state_n;

    logic        [LG-1:0]     row, col;
    logic        [KW-1:0]     k;
    logic        [3:0]        cnt;
    logic        [3:0]        tap_d;
    logic                     pad_d;
    logic signed [DATA_W-1:0] maxv;
    logic signed [DATA_W-1:0] kmem [NUM_KER*10];
    logic        [DATA_W-1:0] lane_out [NUM_KER];
    logic signed [DATA_W-1:0] pix;

    logic [1:0]    tr, tc;
    logic          pad;
    logic [LG-1:0] tap_row, tap_col;
    logic [AW-1:0] pool_idx;
    logic          lane_clr, lane_acc, lane_bias;

    assign busy = (state != IDLE) && (state != DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_KER * 10; i++)
                kmem[i] <= '0;
        end else if (ker_we && !busy && (ker_addr < KAW'(NUM_KER * 10))) begin
            kmem[ker_addr] <= $signed(ker_data);
        end
    end

    // Tap geometry; out-of-image taps read the centre pixel and are zeroed one cycle later.
    always_comb begin
        tr      = (cnt >= 4'd6) ? 2'd2 : (cnt >= 4'd3) ? 2'd1 : 2'd0;
        tc      = 2'(cnt - 4'd3 * {2'b00, tr});
        pad     = (row == '0 && tr == 2'd0) || (row == LAST && tr == 2'd2) ||
                  (col == '0 && tc == 2'd0) || (col == LAST && tc == 2'd2);
        tap_row = row + LG'(tr) - LG'(1);
        tap_col = col + LG'(tc) - LG'(1);
    end

    assign pool_idx = AW'({row[LG-1:1], col[LG-1:1]});
    assign pix      = pad_d ? '0 : $signed(idata);

    for (genvar g = 0; g < NUM_KER; g++) begin : g_lane
        conv_mac_lane #(
            .DATA_W(DATA_W),
            .FRAC  (FRAC)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .clr    (lane_clr),
            .acc_en (lane_acc),
            .bias_en(lane_bias),
            .pix    (pix),
            .weight (kmem[g*10 + int'(tap_d)]),
            .bias   (kmem[g*10 + 9]),
            .out    (lane_out[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        iaddr     = '0;
        cwr       = 1'b0;
        crd       = 1'b0;
        csel      = '0;
        caddr_wr  = '0;
        caddr_rd  = '0;
        cdata_wr  = '0;
        lane_clr  = 1'b0;
        lane_acc  = 1'b0;
        lane_bias = 1'b0;
        case (state)
            IDLE: begin
                if (ready)
                    state_n = CONV_RD;
            end
            CONV_RD: begin
                iaddr    = pad ? {row, col} : {tap_row, tap_col};
                lane_clr = (cnt == 4'd0);
                lane_acc = (cnt != 4'd0);
                if (cnt == 4'd8)
                    state_n = CONV_FIN;
            end
            CONV_FIN: begin
                lane_acc  = (cnt == 4'd0);
                lane_bias = (cnt == 4'd1);
                if (cnt == 4'd1)
                    state_n = CONV_WR;
            end
            CONV_WR: begin
                cwr      = 1'b1;
                csel     = CSW'(csel_l0(k));
                caddr_wr = {row, col};
                cdata_wr = lane_out[k];
                if (k == K_LAST) begin
                    if (row == LAST && col == LAST)
                        state_n = (POOL_EN != 0) ? POOL_RD : DONE;
                    else
                        state_n = CONV_RD;
                end
            end
            POOL_RD: begin
                if (cnt < 4'd4) begin
                    crd      = 1'b1;
                    csel     = CSW'(csel_l0(k));
                    caddr_rd = {row + LG'(cnt[1]), col + LG'(cnt[0])};
                end else begin
                    state_n = POOL_WR;
                end
            end
            POOL_WR: begin
                cwr      = 1'b1;
                csel     = CSW'(csel_l1(k, NUM_KER));
                caddr_wr = pool_idx;
                cdata_wr = maxv;
                state_n  = FLAT_WR;
            end
            FLAT_WR: begin
                cwr      = 1'b1;
                csel     = CSW'(csel_flat(NUM_KER));
                caddr_wr = pool_idx * AW'(NUM_KER) + AW'(k);
                cdata_wr = maxv;
                if (k == K_LAST && row == LAST2 && col == LAST2)
                    state_n = DONE;
                else
                    state_n = POOL_RD;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row   <= '0;
            col   <= '0;
            k     <= '0;
            cnt   <= '0;
            tap_d <= '0;
            pad_d <= 1'b0;
            maxv  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    row <= '0;
                    col <= '0;
                    k   <= '0;
                    cnt <= '0;
                end
                CONV_RD: begin
                    tap_d <= cnt;
                    pad_d <= pad;
                    cnt   <= (cnt == 4'd8) ? 4'd0 : cnt + 4'd1;
                end
                CONV_FIN: begin
                    cnt <= (cnt == 4'd1) ? 4'd0 : cnt + 4'd1;
                    k   <= '0;
                end
                CONV_WR: begin
                    if (k == K_LAST) begin
                        k   <= '0;
                        col <= col + LG'(1);
                        if (col == LAST)
                            row <= row + LG'(1);
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                POOL_RD: begin
                    // First returned word seeds the max, the next three compete with it.
                    if (cnt == 4'd1)
                        maxv <= $signed(cdata_rd);
                    else if (cnt > 4'd1 && $signed(cdata_rd) > maxv)
                        maxv <= $signed(cdata_rd);
                    cnt <= (cnt == 4'd4) ? 4'd0 : cnt + 4'd1;
                end
                FLAT_WR: begin
                    if (k == K_LAST) begin
                        k   <= '0;
                        col <= col + LG'(2);
                        if (col == LAST2)
                            row <= row + LG'(2);
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
